// File: rtl/fft4_seq_if.sv
// Stream bundle for fft4_seq: sample input, result output and status flags.
interface fft4_seq_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_r;
    logic [DW-1:0] in_i;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r;
    logic [DW-1:0] out_i;
    logic [1:0]    out_idx;
    logic          busy;
    logic          done;

    modport slave (
        input  in_valid, in_r, in_i, out_ready,
        output in_ready, out_valid, out_r, out_i, out_idx, busy, done
    );

    modport master (
        output in_valid, in_r, in_i, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_idx, busy, done
    );
endinterface

// File: rtl/fft4_seq.sv
// Sequenced 4-point FFT with one shared complex twiddle multiplier.
// Define FFT4_SCALE_EN to halve every butterfly output (overall gain 1/4).
//
// state  | meaning
// LOAD   | accept x0..x3 into the buffer
// BF1    | stage-1 butterflies, one pair per cycle (r_ph selects the pair)
// TW     | shared multiplier: a2*W0, then a3*W1
// BF2    | stage-2 butterflies, one pair per cycle
// OUT    | stream X0..X3 in natural order
module fft4_seq #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic      clk,
    input  logic      rst,
    fft4_seq_if.slave bus
);
    typedef enum logic [2:0] {S_LOAD, S_BF1, S_TW, S_BF2, S_OUT} state_t;

    localparam logic signed [DW-1:0] W_ONE     = DW'(1 << FRAC);
    localparam logic signed [DW-1:0] W_NEG_ONE = DW'(-(1 << FRAC));

    state_t               r_state;
    state_t               w_next;
    logic                 r_ph;
    logic [1:0]           r_cnt;
    logic [1:0]           r_idx;
    logic signed [DW-1:0] r_br [4];
    logic signed [DW-1:0] r_bi [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_LOAD;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD: if (bus.in_valid && r_cnt == 2'd3) w_next = S_BF1;
            S_BF1:  if (r_ph) w_next = S_TW;
            S_TW:   if (r_ph) w_next = S_BF2;
            S_BF2:  if (r_ph) w_next = S_OUT;
            S_OUT:  if (bus.out_ready && r_idx == 2'd3) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    // In-place butterflies leave the results in bit-reversed slots.
    logic [1:0] w_p, w_q;
    always_comb begin
        w_p = {1'b0, r_ph};
        w_q = {1'b1, r_ph};
        if (r_state == S_BF2) begin
            w_p = {r_ph, 1'b0};
            w_q = {r_ph, 1'b1};
        end
    end

    logic signed [DW-1:0] w_ur, w_ui, w_vr, w_vi;
    logic signed [DW-1:0] w_sum_r, w_sum_i, w_dif_r, w_dif_i;
    assign w_ur = r_br[w_p];
    assign w_ui = r_bi[w_p];
    assign w_vr = r_br[w_q];
    assign w_vi = r_bi[w_q];

`ifdef FFT4_SCALE_EN
    logic signed [DW:0] w_xs_r, w_xs_i, w_xd_r, w_xd_i;
    assign w_xs_r  = {w_ur[DW-1], w_ur} + {w_vr[DW-1], w_vr};
    assign w_xs_i  = {w_ui[DW-1], w_ui} + {w_vi[DW-1], w_vi};
    assign w_xd_r  = {w_ur[DW-1], w_ur} - {w_vr[DW-1], w_vr};
    assign w_xd_i  = {w_ui[DW-1], w_ui} - {w_vi[DW-1], w_vi};
    assign w_sum_r = DW'(w_xs_r >>> 1);
    assign w_sum_i = DW'(w_xs_i >>> 1);
    assign w_dif_r = DW'(w_xd_r >>> 1);
    assign w_dif_i = DW'(w_xd_i >>> 1);
`else
    assign w_sum_r = w_ur + w_vr;
    assign w_sum_i = w_ui + w_vi;
    assign w_dif_r = w_ur - w_vr;
    assign w_dif_i = w_ui - w_vi;
`endif

    // Shared multiplier: slot 1 (a2) with W0 in phase 0, slot 3 (a3) with W1 in phase 1.
    logic [1:0]             w_m;
    logic signed [DW-1:0]   w_ar, w_ai, w_wr, w_wi, w_mul_r, w_mul_i;
    logic signed [2*DW-1:0] w_rr, w_ii, w_ri, w_ir, w_pr_full, w_pi_full;
    assign w_m       = {r_ph, 1'b1};
    assign w_ar      = r_br[w_m];
    assign w_ai      = r_bi[w_m];
    assign w_wr      = r_ph ? '0 : W_ONE;
    assign w_wi      = r_ph ? W_NEG_ONE : '0;
    assign w_rr      = (2*DW)'(w_ar) * (2*DW)'(w_wr);
    assign w_ii      = (2*DW)'(w_ai) * (2*DW)'(w_wi);
    assign w_ri      = (2*DW)'(w_ar) * (2*DW)'(w_wi);
    assign w_ir      = (2*DW)'(w_ai) * (2*DW)'(w_wr);
    assign w_pr_full = w_rr - w_ii;
    assign w_pi_full = w_ri + w_ir;
    assign w_mul_r   = DW'(w_pr_full >>> FRAC);
    assign w_mul_i   = DW'(w_pi_full >>> FRAC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph  <= 1'b0;
            r_cnt <= 2'd0;
            r_idx <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                r_br[k] <= '0;
                r_bi[k] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        r_br[r_cnt] <= bus.in_r;
                        r_bi[r_cnt] <= bus.in_i;
                        r_cnt       <= r_cnt + 2'd1;
                    end
                end
                S_BF1, S_BF2: begin
                    r_br[w_p] <= w_sum_r;
                    r_bi[w_p] <= w_sum_i;
                    r_br[w_q] <= w_dif_r;
                    r_bi[w_q] <= w_dif_i;
                    r_ph      <= ~r_ph;
                end
                S_TW: begin
                    r_br[w_m] <= w_mul_r;
                    r_bi[w_m] <= w_mul_i;
                    r_ph      <= ~r_ph;
                end
                S_OUT: begin
                    if (bus.out_ready) r_idx <= r_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    logic [1:0] w_slot;
    assign w_slot        = {r_idx[0], r_idx[1]};
    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.busy      = (r_state != S_LOAD);
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.out_r     = bus.out_valid ? r_br[w_slot] : '0;
    assign bus.out_i     = bus.out_valid ? r_bi[w_slot] : '0;
    assign bus.out_idx   = r_idx;
    assign bus.done      = bus.out_valid && bus.out_ready && (r_idx == 2'd3);
endmodule
